// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader placed in front of the core's instruction memory.
//   It takes a byte stream over a valid/ready handshake and parses each frame
//   as: LEN_LO, LEN_HI, N*4 little-endian data bytes, then CSUM. Each completed
//   word is written to instruction memory in a one-cycle WRITE slot. The 8-bit
//   sum of every frame byte, CSUM included, must be zero. The core is held
//   until a frame loads with a good checksum.
//
//   Optional build macro: LOADER_TIMEOUT_EN
//     When defined, an inter-byte idle counter runs in LEN1/DATA/CSUM and forces
//     ERR with err_code=11 after TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   byte_valid/_data   upstream byte stream
//   byte_ready         loader can take a byte this cycle
//   reload             one-cycle pulse, restarts loading from DONE or ERR
//   imem_we/addr/wdata instruction memory write port (word-aligned address)
//   core_hold          1 = core stalled
//   load_done          image loaded, checksum good
//   load_error         load failed
//   err_code           00 none, 01 too long, 10 bad checksum, 11 timeout
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          DEPTH_WORDS    = 256,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

    state_t      r_state, w_next;
    logic        r_live;       // low only until the first edge after reset
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_csum;
    logic [23:0] r_word;       // lower three bytes of the word being built
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_err;

    logic        w_accept;
    logic [7:0]  w_sum;
    logic [31:0] w_len;
    logic        w_too_long;
    logic        w_reload;
    logic        w_tmo;

    assign w_accept   = byte_valid && byte_ready;
    assign w_sum      = r_csum + byte_data;
    assign w_len      = {16'd0, byte_data, r_len[7:0]};
    assign w_too_long = (w_len > DEPTH32);
    assign w_reload   = reload && ((r_state == S_DONE) || (r_state == S_ERR));

`ifdef LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_idle;
    logic        w_counting;

    assign w_counting = (r_state == S_LEN1) || (r_state == S_DATA) ||
                        (r_state == S_CSUM);
    assign w_tmo      = w_counting && !w_accept && (r_idle == TMO_LAST);

    // WRITE holds the count so the bubble cycle is not charged to the source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idle <= 32'd0;
        else if (w_accept)
            r_idle <= 32'd0;
        else if (w_counting)
            r_idle <= r_idle + 32'd1;
        else if (r_state != S_WRITE)
            r_idle <= 32'd0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LEN0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN0:  if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if (w_too_long)             w_next = S_ERR;
                    else if (w_len == 32'd0)    w_next = S_CSUM;
                    else                        w_next = S_DATA;
                end else if (w_tmo) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_accept && (r_byte_idx == 2'd3)) w_next = S_WRITE;
                else if (!w_accept && w_tmo)          w_next = S_ERR;
            end
            S_WRITE: begin
                if ((r_word_idx + 16'd1) == r_len) w_next = S_CSUM;
                else                               w_next = S_DATA;
            end
            S_CSUM: begin
                if (w_accept) w_next = (w_sum == 8'd0) ? S_DONE : S_ERR;
                else if (w_tmo) w_next = S_ERR;
            end
            S_DONE:  if (reload) w_next = S_LEN0;
            S_ERR:   if (reload) w_next = S_LEN0;
            default: w_next = S_LEN0;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        core_hold  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (r_state)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: byte_ready = r_live;
            S_WRITE: imem_we    = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                load_done = 1'b1;
            end
            S_ERR:   load_error = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign err_code   = r_err;

    // ---------------- datapath ----------------
    // Address and data are captured as the 4th byte arrives, so they are
    // stable during WRITE and simply hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_csum     <= 8'd0;
            r_word     <= 24'd0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= 32'd0;
            r_err      <= 2'b00;
        end else begin
            if (w_reload) begin
                r_word_idx <= 16'd0;
                r_byte_idx <= 2'd0;
                r_csum     <= 8'd0;
                r_err      <= 2'b00;
            end
            if (w_accept) begin
                r_csum <= w_sum;
                case (r_state)
                    S_LEN0: r_len[7:0] <= byte_data;
                    S_LEN1: begin
                        r_len[15:8] <= byte_data;
                        if (w_too_long) r_err <= 2'b01;
                    end
                    S_DATA: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= byte_data;
                            2'd1: r_word[15:8]  <= byte_data;
                            2'd2: r_word[23:16] <= byte_data;
                            default: begin
                                r_wdata <= {byte_data, r_word};
                                r_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                            end
                        endcase
                    end
                    S_CSUM: if (w_sum != 8'd0) r_err <= 2'b10;
                    default: ;
                endcase
            end
            if (r_state == S_WRITE)
                r_word_idx <= r_word_idx + 16'd1;
            if (w_tmo)
                r_err <= 2'b11;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;

    imem_loader #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .reload(reload),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .load_done(load_done), .load_error(load_error),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every write must be the next one the model predicts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) begin
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr %h data %h want none", imem_addr, imem_wdata);
                end else begin
                    logic [31:0] ea, ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("write_addr", imem_addr, ea);
                    chk("write_data", imem_wdata, ed);
                end
            end
            chk("hold_vs_done", {31'd0, core_hold}, {31'd0, ~load_done});
            chk("we_excl_ready", {31'd0, imem_we & byte_ready}, 32'd0);
            chk("done_excl_err", {31'd0, load_done & load_error}, 32'd0);
        end
    end

    // Behavioural model: expected writes and final error code of a frame.
    task automatic model_frame(input logic [7:0] q[$], output logic [1:0] code);
        int n;
        logic [7:0] sum;
        n = int'(q[0]) + 256 * int'(q[1]);
        if (n > DEPTH) begin
            code = 2'b01;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_addr_q.push_back(BASE + 32'(4 * w));
            exp_data_q.push_back({q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]});
        end
        sum = 8'd0;
        foreach (q[i]) sum = sum + q[i];
        code = (sum == 8'd0) ? 2'b00 : 2'b10;
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic send_bytes(input logic [7:0] q[$], input int mode);
        int i = 0;
        int cyc = 0;
        logic acc;
        while (i < q.size() && cyc < 5000) begin
            case (mode)
                0: byte_valid = 1'b1;
                1: byte_valid = (cyc % 2) == 0;
                default: byte_valid = ($urandom_range(0, 1) == 1);
            endcase
            byte_data = q[i];
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
        end
        byte_valid = 1'b0;
        if (i < q.size()) begin
            total++;
            bad++;
            $display("FAIL send_stall: got %0d bytes taken want %0d", i, q.size());
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] q[$], input int mode);
        logic [1:0] code;
        model_frame(q, code);
        send_bytes(q, mode);
        for (int k = 0; k < 50 && !(load_done || load_error); k++) @(posedge clk);
        #1;
        chk({name, "_done"},  {31'd0, load_done},  {31'd0, code == 2'b00});
        chk({name, "_error"}, {31'd0, load_error}, {31'd0, code != 2'b00});
        chk({name, "_code"},  {30'd0, err_code},   {30'd0, code});
        chk({name, "_hold"},  {31'd0, core_hold},  {31'd0, code != 2'b00});
        chk({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({name, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic do_reload();
        @(posedge clk);
        #1 reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        chk("reload_hold", {31'd0, core_hold}, 32'd1);
        chk("reload_done", {31'd0, load_done}, 32'd0);
        chk("reload_err",  {31'd0, load_error}, 32'd0);
        chk("reload_code", {30'd0, err_code}, 32'd0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we",    {31'd0, imem_we},    32'd0);
        chk("rst_addr",  imem_addr,           BASE);
        chk("rst_wdata", imem_wdata,          32'd0);
        chk("rst_hold",  {31'd0, core_hold},  32'd1);
        chk("rst_done",  {31'd0, load_done},  32'd0);
        chk("rst_err",   {31'd0, load_error}, 32'd0);
        chk("rst_code",  {30'd0, err_code},   32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);
    endtask

    logic [7:0] good[$]    = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                               8'h13, 8'h01, 8'hA0, 8'h00, 8'h67};
    logic [7:0] badcs[$]   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                               8'h13, 8'h01, 8'hA0, 8'h00, 8'h68};
    logic [7:0] toolong[$] = '{8'h01, 8'h01};
    logic [7:0] partial[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                               8'h13, 8'h01};
    logic [7:0] empty[$]   = '{8'h00, 8'h00, 8'h00};
    logic [7:0] stub[$]    = '{8'h02, 8'h00, 8'h93};

    initial begin
        int base_log;
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
        @(posedge clk);
        do_reset();

        // Good two-word frame, valid held high; pin the model with literals.
        base_log = log_addr.size();
        run_frame("good", good, 0);
        chk("good_nwrites", 32'(log_addr.size() - base_log), 32'd2);
        if (log_addr.size() >= base_log + 2) begin
            chk("good_a0", log_addr[base_log],     32'h0000_0000);
            chk("good_d0", log_data[base_log],     32'h0050_0093);
            chk("good_a1", log_addr[base_log + 1], 32'h0000_0004);
            chk("good_d1", log_data[base_log + 1], 32'h00A0_0113);
        end

        do_reload();
        run_frame("badcsum", badcs, 0);
        chk("badcsum_code_lit", {30'd0, err_code}, 32'd2);

        do_reload();
        base_log = log_addr.size();
        run_frame("toolong", toolong, 0);
        chk("toolong_code_lit", {30'd0, err_code}, 32'd1);
        chk("toolong_nwrites", 32'(log_addr.size() - base_log), 32'd0);

        // Throttled source must produce identical writes.
        do_reload();
        base_log = log_addr.size();
        run_frame("throttle", good, 1);
        if (log_addr.size() >= base_log + 2) begin
            chk("thr_d0", log_data[base_log],     32'h0050_0093);
            chk("thr_a1", log_addr[base_log + 1], 32'h0000_0004);
            chk("thr_d1", log_data[base_log + 1], 32'h00A0_0113);
        end

        // Reset mid-frame after 6 data bytes; only word 0 was written.
        do_reload();
        exp_addr_q.push_back(32'h0000_0000);
        exp_data_q.push_back(32'h0050_0093);
        send_bytes(partial, 0);
        chk("partial_pending", 32'(exp_addr_q.size()), 32'd0);
        do_reset();
        base_log = log_addr.size();
        run_frame("after_rst", good, 0);
        chk("after_rst_nwrites", 32'(log_addr.size() - base_log), 32'd2);

        // Empty image.
        do_reload();
        base_log = log_addr.size();
        run_frame("empty", empty, 0);
        chk("empty_nwrites", 32'(log_addr.size() - base_log), 32'd0);

        // Idle in DATA for 20 cycles.
        do_reload();
        send_bytes(stub, 0);
        repeat (20) @(posedge clk);
        #1;
`ifdef LOADER_TIMEOUT_EN
        chk("tmo_error", {31'd0, load_error}, 32'd1);
        chk("tmo_code",  {30'd0, err_code},   32'd3);
        chk("tmo_ready", {31'd0, byte_ready}, 32'd0);
`else
        chk("idle_error", {31'd0, load_error}, 32'd0);
        chk("idle_ready", {31'd0, byte_ready}, 32'd1);
`endif
        do_reset();

        // Randomized frames with random valid gaps.
        for (int f = 0; f < 24; f++) begin
            logic [7:0] q[$];
            int n;
            logic [7:0] s;
            q = {};
            if (f % 8 == 7) n = 257 + $urandom_range(0, 300);
            else            n = $urandom_range(0, 6);
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            if (n <= DEPTH) begin
                for (int b = 0; b < 4 * n; b++) q.push_back(8'($urandom));
                s = 8'd0;
                foreach (q[i]) s = s + q[i];
                if ($urandom_range(0, 3) == 0) q.push_back(8'(-s + 8'($urandom_range(1, 255))));
                else                           q.push_back(8'(-s));
            end
            if (f > 0) do_reload();
            run_frame("rand", q, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles little-endian 32-bit words, writes them into instruction memory and checks a frame checksum.
- Holds the core (PC and register writes) until a good image is loaded; releases it afterwards.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction word written.
- DEPTH_WORDS, 256: instruction memory capacity in words; the maximum accepted word count.
- TIMEOUT_CYCLES, 100000: inter-byte idle limit. Used only with LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid and byte_ready are both high at a rising clk edge
- reload  in  1  single-cycle pulse; restarts loading from the DONE or ERR state
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  32  word-aligned byte address
- imem_wdata  out  32  assembled instruction word
- core_hold  out  1  1 = core stalled / held in reset
- load_done  out  1  image loaded and checksum good (sticky)
- load_error  out  1  load failed (sticky)
- err_code  out  2  00 none, 01 length > DEPTH_WORDS, 10 bad checksum, 11 timeout

Behaviour:
- Reset is asynchronous, active-low.
- Values under reset: state=LEN0, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, load_done=0, load_error=0, err_code=00; word index, byte index and checksum accumulator = 0.
- byte_ready goes high in the first cycle after rst_n deasserts.
- Frame format:
  - LEN_LO, LEN_HI: word count N, 16 bits, little-endian.
  - N×4 data bytes, each word little-endian (least significant byte first).
  - One CSUM byte.
- The 8-bit sum, mod 256, of every frame byte including CSUM must be 0x00.
- States:
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI.
    - If N > DEPTH_WORDS → ERR, err_code=01.
    - If N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accept bytes into word bit positions [8k+7:8k], k = byte index 0..3. When the 4th byte is accepted → WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr = BASE_ADDR + 4×word_index, imem_wdata = assembled word.
    - byte_ready=0.
    - Word index increments. If it now equals N → CSUM, else → DATA.
  - CSUM: accept one byte. If the running sum including this byte == 0 → DONE, else → ERR with err_code=10.
  - DONE: core_hold=0, load_done=1, byte_ready=0. On reload → LEN0.
  - ERR: core_hold=1, load_error=1, byte_ready=0. On reload → LEN0.
- On reload:
  - core_hold=1 in the cycle after the pulse.
  - load_done, load_error and err_code cleared.
  - Word index, byte index and checksum accumulator cleared.
- byte_ready is combinationally high only in LEN0, LEN1, DATA and CSUM.
- Throughput: one byte per cycle, except one bubble cycle per word (the WRITE cycle).
- Bytes offered while byte_ready=0 are not consumed. The upstream source must hold them.
- reload is ignored in LEN0, LEN1, DATA, WRITE and CSUM.
- imem_we is never asserted outside WRITE. At most N writes occur per frame.
- Address arithmetic is 32-bit, modulo 2^32. Words are always aligned.
- rst_n asserted mid-frame: immediate return to the reset values above, including a partial word being discarded. Words already written remain in memory, but load_done=0.
- imem_addr and imem_wdata hold their last values outside WRITE.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in LEN1, DATA and CSUM. It counts cycles in which no byte is accepted.
  - The counter resets on every accepted byte and on entry to LEN1.
  - The WRITE cycle does not count.
  - When the count reaches TIMEOUT_CYCLES → ERR, err_code=11.
  - LEN0 waits forever.
- Not defined: no counter is instantiated, err_code=11 is unreachable, and the loader waits indefinitely in every state.

Test Plan:
- Good two-word load, bytes 02 00 93 00 50 00 13 01 A0 00 67, byte_valid held high:
  - imem_we pulses twice: addr 0x0 with data 0x00500093, then addr 0x4 with data 0x00A00113.
  - load_done=1, core_hold=0, err_code=00.
- Same stream with CSUM=0x68: both writes still occur; ends in ERR with load_error=1, err_code=10, core_hold=1.
- N=257 with DEPTH_WORDS=256, bytes 01 01:
  - ERR immediately after LEN_HI with err_code=01.
  - No imem_we pulse; byte_ready=0 afterwards.
- Throttled source: byte_valid toggling every other cycle during the two-word load gives identical write data and addresses. Each WRITE cycle shows byte_ready=0 and no byte consumed.
- rst_n pulsed low after 6 data bytes, then the full good frame sent: exactly the two correct writes follow, and load_done=1. Then reload is pulsed with N=0, CSUM=00: core_hold=1 for the duration, then DONE with zero writes.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 02 00 93, then idle ≥16 cycles → ERR with err_code=11. Without the macro, the loader stays in DATA with byte_ready=1.
